// File: rtl/cfu_pkg.sv
`default_nettype none
// ============================================================================
// Module : cfu_pkg
// Brief  : Shared control-flow op codes, redirect FSM states and the
//          branch-direction helper used by the execute-stage redirect unit.
// Rev    : 1.0  initial release
// ============================================================================
package cfu_pkg;

    localparam int INSN_BYTES = 4;

    typedef enum logic [3:0] {
        BEQ  = 4'd0,
        BNE  = 4'd1,
        BLT  = 4'd2,
        BGE  = 4'd3,
        BLTU = 4'd4,
        BGEU = 4'd5,
        JAL  = 4'd6,
        JALR = 4'd7,
        NB   = 4'd8
    } cfuop_t;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REDIRECT = 2'd1,
        SHADOW   = 2'd2
    } cfu_state_t;

    // Direction from pre-computed operand relations, so the helper stays
    // independent of the datapath width. Unknown encodings are not taken.
    function automatic logic cfu_branch_taken(input cfuop_t op,
                                              input logic   eq,
                                              input logic   lt_s,
                                              input logic   lt_u);
        logic t;
        t = 1'b0;
        case (op)
            BEQ:     t = eq;
            BNE:     t = !eq;
            BLT:     t = lt_s;
            BGE:     t = !lt_s;
            BLTU:    t = lt_u;
            BGEU:    t = !lt_u;
            JAL:     t = 1'b1;
            JALR:    t = 1'b1;
            default: t = 1'b0;
        endcase
        return t;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cfu_eval.sv
`default_nettype none
// ============================================================================
// Module : cfu_eval
// Brief  : Combinational branch resolution: direction, target and the
//          architecturally correct next PC for one control-flow op.
// Rev    : 1.0  initial release
// ============================================================================
module cfu_eval
    import cfu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  cfuop_t            cfuop_i,
    input  logic [XLEN-1:0]   pc_i,
    input  logic [XLEN-1:0]   rs1_i,
    input  logic [XLEN-1:0]   rs2_i,
    input  logic [XLEN-1:0]   imm_i,
    output logic              taken_o,
    output logic [XLEN-1:0]   target_o,
    output logic [XLEN-1:0]   next_pc_o
);

    logic            eq;
    logic            lt_s;
    logic            lt_u;
    logic            is_jalr;
    logic [XLEN-1:0] base;
    logic [XLEN-1:0] sum;

    assign eq      = (rs1_i == rs2_i);
    assign lt_s    = ($signed(rs1_i) < $signed(rs2_i));
    assign lt_u    = (rs1_i < rs2_i);
    assign taken_o = cfu_branch_taken(cfuop_i, eq, lt_s, lt_u);

    // JALR is register-relative and its target is halfword aligned; every
    // other op is PC-relative. Adds wrap silently.
    assign is_jalr   = (cfuop_i == JALR);
    assign base      = is_jalr ? rs1_i : pc_i;
    assign sum       = base + imm_i;
    assign target_o  = is_jalr ? {sum[XLEN-1:1], 1'b0} : sum;
    assign next_pc_o = taken_o ? target_o : (pc_i + XLEN'(INSN_BYTES));

endmodule
`default_nettype wire

// File: rtl/cfu_redirect_unit.sv
`default_nettype none
// ============================================================================
// Module : cfu_redirect_unit
// Brief  : Execute-stage control-flow resolver. Compares the resolved
//          outcome with the fetch prediction, issues a held redirect request
//          plus a one-cycle flush on mismatch, masks wrong-path work for a
//          shadow window and keeps saturating statistics.
// Rev    : 1.0  initial release
// ============================================================================
module cfu_redirect_unit
    import cfu_pkg::*;
#(
    parameter int XLEN          = 32,
    parameter int SHADOW_CYCLES = 2,
    parameter int CNT_W         = 32
) (
    input  logic              clk,
    input  logic              arst_n,
    input  logic              valid_i,
    input  logic              stall_i,
    input  logic [3:0]        cfuop_i,
    input  logic [XLEN-1:0]   pc_i,
    input  logic [XLEN-1:0]   rs1_i,
    input  logic [XLEN-1:0]   rs2_i,
    input  logic [XLEN-1:0]   imm_i,
    input  logic              pred_taken_i,
    input  logic [XLEN-1:0]   pred_target_i,
    output logic              taken_o,
    output logic [XLEN-1:0]   link_o,
    output logic              redirect_valid_o,
    input  logic              redirect_ready_i,
    output logic [XLEN-1:0]   redirect_pc_o,
    output logic              flush_o,
    output logic [CNT_W-1:0]  branch_cnt_o,
    output logic [CNT_W-1:0]  mispred_cnt_o
);

    localparam int SH_W = (SHADOW_CYCLES < 1) ? 1 : $clog2(SHADOW_CYCLES + 1);

    cfuop_t          op;
    logic [XLEN-1:0] target;
    logic [XLEN-1:0] next_pc;
    logic            resolve;
    logic            mispredict;
    logic            branch_inc;

    cfu_state_t      state_q,  state_d;
    logic [SH_W-1:0] shadow_q, shadow_d;
    logic            rvalid_q, rvalid_d;
    logic [XLEN-1:0] rpc_q,    rpc_d;
    logic            flush_q,  flush_d;
    logic [CNT_W-1:0] br_cnt_q, br_cnt_d;
    logic [CNT_W-1:0] mp_cnt_q, mp_cnt_d;

    assign op = cfuop_t'(cfuop_i);

    cfu_eval #(
        .XLEN (XLEN)
    ) u_eval (
        .cfuop_i   (op),
        .pc_i      (pc_i),
        .rs1_i     (rs1_i),
        .rs2_i     (rs2_i),
        .imm_i     (imm_i),
        .taken_o   (taken_o),
        .target_o  (target),
        .next_pc_o (next_pc)
    );

    assign link_o = pc_i + XLEN'(INSN_BYTES);

    // Only a non-stalled instruction seen in IDLE is on the correct path.
    assign resolve    = valid_i && !stall_i && (state_q == IDLE);
    assign mispredict = resolve &&
                        ((taken_o != pred_taken_i) ||
                         (taken_o && pred_taken_i && (target != pred_target_i)));
    assign branch_inc = resolve && (op != NB);

    // Next-state logic for the redirect handshake and shadow window.
    always_comb begin
        state_d  = state_q;
        shadow_d = shadow_q;
        rvalid_d = rvalid_q;
        rpc_d    = rpc_q;
        flush_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (mispredict) begin
                    rpc_d    = next_pc;
                    rvalid_d = 1'b1;
                    flush_d  = 1'b1;
                    state_d  = REDIRECT;
                end
            end
            REDIRECT: begin
                if (redirect_ready_i) begin
                    rvalid_d = 1'b0;
                    if (SHADOW_CYCLES == 0) begin
                        state_d = IDLE;
                    end else begin
                        shadow_d = SH_W'(SHADOW_CYCLES);
                        state_d  = SHADOW;
                    end
                end
            end
            SHADOW: begin
                if (shadow_q <= SH_W'(1)) begin
                    shadow_d = '0;
                    state_d  = IDLE;
                end else begin
                    shadow_d = shadow_q - SH_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Saturating statistics: hold at all-ones instead of wrapping.
    always_comb begin
        br_cnt_d = br_cnt_q;
        mp_cnt_d = mp_cnt_q;
        if (branch_inc && (br_cnt_q != '1)) br_cnt_d = br_cnt_q + CNT_W'(1);
        if (mispredict && (mp_cnt_q != '1)) mp_cnt_d = mp_cnt_q + CNT_W'(1);
    end

    // State, redirect request and counter registers.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q  <= IDLE;
            shadow_q <= '0;
            rvalid_q <= 1'b0;
            rpc_q    <= '0;
            flush_q  <= 1'b0;
            br_cnt_q <= '0;
            mp_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            shadow_q <= shadow_d;
            rvalid_q <= rvalid_d;
            rpc_q    <= rpc_d;
            flush_q  <= flush_d;
            br_cnt_q <= br_cnt_d;
            mp_cnt_q <= mp_cnt_d;
        end
    end

    assign redirect_valid_o = rvalid_q;
    assign redirect_pc_o    = rpc_q;
    assign flush_o          = flush_q;
    assign branch_cnt_o     = br_cnt_q;
    assign mispred_cnt_o    = mp_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_cfu_redirect_unit.sv
`default_nettype none
// ============================================================================
// Module : tb_cfu_redirect_unit
// Brief  : Self-checking bench for cfu_redirect_unit (4-bit counters).
// Rev    : 1.0  initial release
// ============================================================================
module tb_cfu_redirect_unit;

    localparam int XLEN  = 32;
    localparam int SHAD  = 2;
    localparam int CNT_W = 4;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              arst_n;
    logic              valid_i;
    logic              stall_i;
    logic [3:0]        cfuop_i;
    logic [XLEN-1:0]   pc_i, rs1_i, rs2_i, imm_i, pred_target_i;
    logic              pred_taken_i;
    logic              taken_o;
    logic [XLEN-1:0]   link_o;
    logic              redirect_valid_o;
    logic              redirect_ready_i;
    logic [XLEN-1:0]   redirect_pc_o;
    logic              flush_o;
    logic [CNT_W-1:0]  branch_cnt_o, mispred_cnt_o;

    cfu_redirect_unit #(
        .XLEN          (XLEN),
        .SHADOW_CYCLES (SHAD),
        .CNT_W         (CNT_W)
    ) dut (
        .clk              (clk),
        .arst_n           (arst_n),
        .valid_i          (valid_i),
        .stall_i          (stall_i),
        .cfuop_i          (cfuop_i),
        .pc_i             (pc_i),
        .rs1_i            (rs1_i),
        .rs2_i            (rs2_i),
        .imm_i            (imm_i),
        .pred_taken_i     (pred_taken_i),
        .pred_target_i    (pred_target_i),
        .taken_o          (taken_o),
        .link_o           (link_o),
        .redirect_valid_o (redirect_valid_o),
        .redirect_ready_i (redirect_ready_i),
        .redirect_pc_o    (redirect_pc_o),
        .flush_o          (flush_o),
        .branch_cnt_o     (branch_cnt_o),
        .mispred_cnt_o    (mispred_cnt_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] pc, rs1, rs2, imm;
        logic        pt;
        logic [31:0] ptg;
        logic        exp_taken;
        logic        exp_redir;
        logic [31:0] exp_rpc;
    } vec_t;

    localparam int NV = 12;
    vec_t        vecs[NV];
    logic [31:0] sb_q[$];
    int          total = 0;
    int          bad   = 0;
    int          m_br  = 0;
    int          m_mp  = 0;

    function automatic vec_t mk(input logic [3:0] op, input logic [31:0] pc,
                                input logic [31:0] rs1, input logic [31:0] rs2,
                                input logic [31:0] imm, input logic pt,
                                input logic [31:0] ptg, input logic et,
                                input logic er, input logic [31:0] erpc);
        vec_t v;
        v.op = op; v.pc = pc; v.rs1 = rs1; v.rs2 = rs2; v.imm = imm;
        v.pt = pt; v.ptg = ptg; v.exp_taken = et; v.exp_redir = er;
        v.exp_rpc = erpc;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply(input vec_t v);
        cfuop_i       = v.op;
        pc_i          = v.pc;
        rs1_i         = v.rs1;
        rs2_i         = v.rs2;
        imm_i         = v.imm;
        pred_taken_i  = v.pt;
        pred_target_i = v.ptg;
        valid_i       = 1'b1;
    endtask

    task automatic bump_br();
        if (m_br < CMAX) m_br++;
    endtask

    task automatic bump_mp();
        if (m_mp < CMAX) m_mp++;
    endtask

    task automatic chk_counts(input string tag);
        chk({tag, "_brcnt"}, 32'(branch_cnt_o), 32'(m_br));
        chk({tag, "_mpcnt"}, 32'(mispred_cnt_o), 32'(m_mp));
    endtask

    // Scoreboard pop on a freshly raised redirect request.
    task automatic sb_check(input string tag);
        if (sb_q.size() == 0) begin
            chk({tag, "_sb_unexpected"}, 32'(redirect_valid_o), 32'd0);
        end else begin
            chk({tag, "_rpc"}, redirect_pc_o, sb_q.pop_front());
        end
    endtask

    // Return the DUT to IDLE after an outstanding redirect.
    task automatic drain();
        redirect_ready_i = 1'b1;
        step();
        redirect_ready_i = 1'b0;
        step();
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = mk(4'd0, 32'h100, 32'd5, 32'd5, 32'h20, 1'b0, 32'h0,   1'b1, 1'b1, 32'h120);
        vecs[1]  = mk(4'd2, 32'h200, 32'hFFFFFFFF, 32'd1, 32'h40, 1'b1, 32'h240, 1'b1, 1'b0, 32'h0);
        vecs[2]  = mk(4'd4, 32'h200, 32'hFFFFFFFF, 32'd1, 32'h40, 1'b1, 32'h240, 1'b0, 1'b1, 32'h204);
        vecs[3]  = mk(4'd7, 32'h300, 32'h1001, 32'd0, 32'h4, 1'b1, 32'h1004, 1'b1, 1'b0, 32'h0);
        vecs[4]  = mk(4'd1, 32'h400, 32'd3, 32'd3, 32'h8, 1'b0, 32'h0,    1'b0, 1'b0, 32'h0);
        vecs[5]  = mk(4'd3, 32'h500, 32'hFFFFFFFF, 32'd1, 32'h10, 1'b1, 32'h510, 1'b0, 1'b1, 32'h504);
        vecs[6]  = mk(4'd5, 32'h500, 32'hFFFFFFFF, 32'd1, 32'h10, 1'b1, 32'h999, 1'b1, 1'b1, 32'h510);
        vecs[7]  = mk(4'd6, 32'h600, 32'd0, 32'd0, 32'hFFFFFFF0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h5F0);
        vecs[8]  = mk(4'd8, 32'h700, 32'd0, 32'd0, 32'h0, 1'b1, 32'h800,  1'b0, 1'b1, 32'h704);
        vecs[9]  = mk(4'hF, 32'h780, 32'd0, 32'd0, 32'h0, 1'b0, 32'h0,    1'b0, 1'b0, 32'h0);
        vecs[10] = mk(4'd6, 32'hFFFFFFF0, 32'd0, 32'd0, 32'h20, 1'b1, 32'h10, 1'b1, 1'b0, 32'h0);
        vecs[11] = mk(4'd0, 32'h880, 32'd1, 32'd2, 32'h40, 1'b1, 32'h8C0, 1'b0, 1'b1, 32'h884);

        // Reset state; combinational path alive while in reset.
        arst_n = 1'b0; valid_i = 1'b0; stall_i = 1'b0; redirect_ready_i = 1'b0;
        apply(vecs[0]);
        valid_i = 1'b0;
        #3;
        chk("rst_taken", 32'(taken_o), 32'd1);
        chk("rst_link", link_o, 32'h104);
        chk("rst_rvalid", 32'(redirect_valid_o), 32'd0);
        chk("rst_rpc", redirect_pc_o, 32'd0);
        chk("rst_flush", 32'(flush_o), 32'd0);
        chk_counts("rst");
        step();
        arst_n = 1'b1;
        step();

        // Table-driven single resolutions.
        for (int i = 0; i < NV; i++) begin
            apply(vecs[i]);
            @(negedge clk);
            chk($sformatf("v%0d_taken", i), 32'(taken_o), 32'(vecs[i].exp_taken));
            chk($sformatf("v%0d_link", i), link_o, vecs[i].pc + 32'd4);
            if (vecs[i].exp_redir) sb_q.push_back(vecs[i].exp_rpc);
            step();
            valid_i = 1'b0;
            chk($sformatf("v%0d_flush", i), 32'(flush_o), 32'(vecs[i].exp_redir));
            chk($sformatf("v%0d_rvalid", i), 32'(redirect_valid_o), 32'(vecs[i].exp_redir));
            if (redirect_valid_o) sb_check($sformatf("v%0d", i));
            if (vecs[i].op != 4'd8) bump_br();
            if (vecs[i].exp_redir) bump_mp();
            chk_counts($sformatf("v%0d", i));
            if (vecs[i].exp_redir) begin
                redirect_ready_i = 1'b1;
                step();
                redirect_ready_i = 1'b0;
                chk($sformatf("v%0d_accept", i), 32'(redirect_valid_o), 32'd0);
                step();
                step();
            end
        end

        // Back-pressure, then shadow window with wrong-path traffic.
        apply(mk(4'd0, 32'h800, 32'd7, 32'd7, 32'h10, 1'b0, 32'h0, 1'b1, 1'b1, 32'h810));
        sb_q.push_back(32'h810);
        step();
        chk("bp_rvalid", 32'(redirect_valid_o), 32'd1);
        chk("bp_flush", 32'(flush_o), 32'd1);
        sb_check("bp");
        bump_br(); bump_mp();
        apply(mk(4'd6, 32'h900, 32'd0, 32'd0, 32'h40, 1'b0, 32'h0, 1'b1, 1'b1, 32'h940));
        for (int k = 0; k < 3; k++) begin
            step();
            chk($sformatf("bp%0d_rvalid", k), 32'(redirect_valid_o), 32'd1);
            chk($sformatf("bp%0d_flush", k), 32'(flush_o), 32'd0);
            chk($sformatf("bp%0d_rpc", k), redirect_pc_o, 32'h810);
            chk_counts($sformatf("bp%0d", k));
        end
        redirect_ready_i = 1'b1;
        step();
        redirect_ready_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("sh%0d_rvalid", k), 32'(redirect_valid_o), 32'd0);
            chk($sformatf("sh%0d_flush", k), 32'(flush_o), 32'd0);
            chk_counts($sformatf("sh%0d", k));
            if (k < 2) step();
        end
        sb_q.push_back(32'h940);
        step();
        valid_i = 1'b0;
        chk("post_sh_rvalid", 32'(redirect_valid_o), 32'd1);
        chk("post_sh_flush", 32'(flush_o), 32'd1);
        sb_check("post_sh");
        bump_br(); bump_mp();
        chk_counts("post_sh");
        drain();

        // Stall blocks resolution; ready with no request does nothing.
        apply(mk(4'd0, 32'hA00, 32'd9, 32'd9, 32'h4, 1'b0, 32'h0, 1'b1, 1'b1, 32'hA04));
        stall_i = 1'b1;
        redirect_ready_i = 1'b1;
        step();
        redirect_ready_i = 1'b0;
        chk("stall_rvalid", 32'(redirect_valid_o), 32'd0);
        chk("stall_flush", 32'(flush_o), 32'd0);
        chk_counts("stall");
        stall_i = 1'b0;
        sb_q.push_back(32'hA04);
        step();
        valid_i = 1'b0;
        chk("unstall_rvalid", 32'(redirect_valid_o), 32'd1);
        sb_check("unstall");
        bump_br(); bump_mp();
        chk_counts("unstall");

        // Asynchronous reset while a redirect is outstanding.
        #2;
        arst_n = 1'b0;
        #1;
        m_br = 0; m_mp = 0;
        chk("arst_rvalid", 32'(redirect_valid_o), 32'd0);
        chk("arst_flush", 32'(flush_o), 32'd0);
        chk_counts("arst");
        step();
        arst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            apply(mk(4'd1, 32'hE00 + 32'(16 * k), 32'd1, 32'd2, 32'h20, 1'b1,
                     32'hE20 + 32'(16 * k), 1'b1, 1'b0, 32'h0));
            step();
            chk($sformatf("ok%0d_rvalid", k), 32'(redirect_valid_o), 32'd0);
            chk($sformatf("ok%0d_flush", k), 32'(flush_o), 32'd0);
            bump_br();
        end
        valid_i = 1'b0;
        chk_counts("ok");

        // Saturation: 17 NB mispredicts with ready held high.
        apply(mk(4'd8, 32'hB00, 32'd0, 32'd0, 32'h0, 1'b1, 32'hC00, 1'b0, 1'b1, 32'hB04));
        redirect_ready_i = 1'b1;
        for (int k = 0; k < 17; k++) begin
            sb_q.push_back(32'hB04);
            step();
            chk($sformatf("sat%0d_rvalid", k), 32'(redirect_valid_o), 32'd1);
            sb_check($sformatf("sat%0d", k));
            bump_mp();
            step();
            step();
            step();
        end
        valid_i = 1'b0;
        redirect_ready_i = 1'b0;
        step();
        chk_counts("sat");
        chk("sat_mp_max", 32'(mispred_cnt_o), 32'hF);
        chk("sb_left", 32'(sb_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cfu_redirect_unit.md
Name: cfu_redirect_unit

Overview:
- Execute-stage consumer of the control-flow op code produced at decode (cfuop_t: BEQ, BNE, BLT, BGE, BLTU, BGEU, JAL, JALR, NB).
- Resolves branch direction and target, and compares both against the fetch-stage prediction.
- On a mismatch, holds a redirect request to fetch with a valid/ready handshake and pulses a pipeline flush.
- Suppresses wrong-path resolutions during a shadow window and keeps saturating branch and mispredict counters.

Parameters:
- XLEN, 32, datapath and PC width.
- SHADOW_CYCLES, 2, cycles after redirect acceptance during which valid_i is ignored (0 = none).
- CNT_W, 32, width of the statistics counters.

Ports:
- clk  in  1  clock.
- arst_n  in  1  asynchronous active-low reset.
- valid_i  in  1  execute-stage instruction valid.
- stall_i  in  1  execute stalled; no resolution this cycle.
- cfuop_i  in  4  cfuop_t from cfu_pkg.
- pc_i  in  XLEN  instruction PC.
- rs1_i  in  XLEN  operand 1.
- rs2_i  in  XLEN  operand 2.
- imm_i  in  XLEN  sign-extended immediate.
- pred_taken_i  in  1  fetch predicted taken.
- pred_target_i  in  XLEN  fetch predicted target.
- taken_o  out  1  combinational actual taken.
- link_o  out  XLEN  combinational pc_i+4 (rd write data for JAL/JALR).
- redirect_valid_o  out  1  registered redirect request.
- redirect_ready_i  in  1  fetch accepts redirect.
- redirect_pc_o  out  XLEN  registered correct next PC.
- flush_o  out  1  registered one-cycle flush pulse.
- branch_cnt_o  out  CNT_W  resolved control-flow instructions.
- mispred_cnt_o  out  CNT_W  mispredictions.

Behaviour:
- Reset (arst_n low, asynchronous): state IDLE; redirect_valid_o=0, redirect_pc_o=0, flush_o=0, both counters=0, shadow counter=0. Combinational outputs follow inputs even during reset.
- Taken rules:
  - BEQ: rs1==rs2. BNE: !=.
  - BLT / BGE: signed < / >=.
  - BLTU / BGEU: unsigned < / >=.
  - JAL and JALR: always taken.
  - NB, and any encoding > NB: not taken.
- Target rules:
  - JALR: (rs1+imm) with bit0 cleared.
  - All others: pc+imm.
  - All adds are modulo 2^XLEN (wrap, no overflow flag).
- Actual next PC: taken ? target : pc+4.
- Mispredict = resolve & ((taken != pred_taken_i) | (taken & pred_taken_i & target != pred_target_i)), where resolve = valid_i & !stall_i & state==IDLE.
- State machine:
  - IDLE: on mispredict, redirect_pc_o <= actual next PC, redirect_valid_o <= 1, flush_o <= 1 for exactly one cycle (registered, so visible the cycle after resolution); go to REDIRECT.
  - REDIRECT: hold redirect_valid_o and redirect_pc_o stable until redirect_ready_i; ignore valid_i. On the ready cycle, redirect_valid_o <= 0. If SHADOW_CYCLES==0 go to IDLE, else load the shadow counter with SHADOW_CYCLES and go to SHADOW.
  - SHADOW: ignore valid_i; decrement each cycle regardless of stall_i; when the counter reaches 1, go to IDLE on the next edge.
- Latency: redirect request 1 cycle after resolution. Minimum mispredict-to-next-resolve is 2 + SHADOW_CYCLES cycles when ready is high immediately.
- Counters:
  - branch_cnt increments on resolve & cfuop != NB.
  - mispred_cnt increments on mispredict.
  - Both saturate at all-ones and never wrap.
- Simultaneous events:
  - A valid_i arriving on the same cycle as redirect_ready_i is ignored (state is REDIRECT).
  - stall_i high with valid_i: no state change, no counting.
  - redirect_ready_i while redirect_valid_o=0 has no effect.
- A correctly predicted control-flow instruction produces no redirect and no flush.

Decomposition:
- cfu_pkg gains:
  - cfu_state_t enum {IDLE, REDIRECT, SHADOW};
  - a helper function for the branch compare;
  - constant INSN_BYTES=4.
- cfuop_t stays the single definition in cfu_pkg.
- One combinational sub-module, cfu_eval: cfuop, operands, pc and imm in; taken, target and next PC out. The FSM, handshake and counters live in cfu_redirect_unit.

Test Plan:
- BEQ, rs1=rs2=5, pc=0x100, imm=0x20, pred_taken=0 -> taken_o=1; next cycle redirect_valid_o=1, redirect_pc_o=0x120, flush_o=1 for one cycle; mispred_cnt=1.
- BLT vs BLTU with rs1=0xFFFFFFFF, rs2=1, pred_taken=1, pred_target=pc+imm -> BLT: no redirect. BLTU: redirect_pc_o=pc+4.
- JALR, rs1=0x1001, imm=0x4, pred_taken=1, pred_target=0x1004 -> no redirect (target 0x1004, bit0 cleared); link_o=pc+4; branch_cnt increments.
- Mispredict with redirect_ready_i low for 3 cycles, new valid_i each cycle -> redirect_pc_o stable, flush_o single pulse, counters frozen. With ready high, 2 shadow cycles of ignored valid_i, then the next mispredict redirects again.
- Assert arst_n low while in REDIRECT -> redirect_valid_o and flush_o go 0 immediately, counters 0; after release, a correct-prediction stream gives no redirect.
- CNT_W=4: 17 mispredicts -> mispred_cnt_o stays 0xF; cfuop=NB with pred_taken=1 -> redirect to pc+4, branch_cnt unchanged.
